// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - I/D cache line-transaction arbiter for the shared memory bus
`ifndef MEM_READ
`define MEM_READ 13'h1100
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h0100
`endif

module mem_bus_arbiter #(
    parameter int ADDRESS_SIZE   = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_req,
    input  logic [ADDRESS_SIZE-1:0]   i_addr,
    output logic                      i_rvalid,
    output logic [BUS_DATA_WIDTH-1:0] i_rdata,
    output logic                      i_done,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDRESS_SIZE-1:0]   d_addr,
    input  logic [BUS_DATA_WIDTH-1:0] d_wdata,
    output logic                      d_wnext,
    output logic                      d_rvalid,
    output logic [BUS_DATA_WIDTH-1:0] d_rdata,
    output logic                      d_done,
    output logic [2:0]                beat,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam logic [BUS_TAG_WIDTH-1:0] TAG_READ  = BUS_TAG_WIDTH'(`MEM_READ);
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_WRITE = BUS_TAG_WIDTH'(`MEM_WRITE);
    localparam logic [2:0]               LAST_BEAT = 3'(BEATS - 1);
    localparam logic [3:0]               ALL_BEATS = 4'(BEATS);
    localparam logic [ADDRESS_SIZE-1:0]  LINE_MASK = ~ADDRESS_SIZE'(63);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RESP, DONE} state_t;

    state_t                    state, state_nx;
    logic                      owner_d;       // 1: D owns the bus, 0: I
    logic                      last_grant_d;
    logic                      we_q;
    logic                      rvalid_q;
    logic                      respack_q;
    logic [ADDRESS_SIZE-1:0]   line_addr;
    logic [BUS_DATA_WIDTH-1:0] rdata_q;
    logic [2:0]                beat_q;
    logic [3:0]                rcnt;
    logic                      grant_d;
    logic                      resp_match;
    logic [BUS_TAG_WIDTH-1:0]  issued_tag;

    assign grant_d    = (i_req && d_req) ? ~last_grant_d : d_req;
    assign issued_tag = we_q ? TAG_WRITE : TAG_READ;
    // Beats beyond the eighth are never forwarded, so the line cannot wrap.
    assign resp_match = bus_respcyc && (bus_resptag == issued_tag) && (rcnt != ALL_BEATS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nx = ADDR;
            ADDR:    if (bus_reqack) state_nx = we_q ? WDATA : RESP;
            WDATA:   if (bus_reqack && beat_q == LAST_BEAT) state_nx = DONE;
            RESP:    if (rvalid_q && beat_q == LAST_BEAT) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_d      <= 1'b0;
            last_grant_d <= 1'b1;
            we_q         <= 1'b0;
            line_addr    <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            respack_q    <= 1'b0;
            beat_q       <= 3'd0;
            rcnt         <= 4'd0;
        end else begin
            rvalid_q  <= 1'b0;
            respack_q <= 1'b0;
            case (state)
                IDLE: if (i_req || d_req) begin
                    owner_d   <= grant_d;
                    we_q      <= grant_d & d_we;
                    line_addr <= (grant_d ? d_addr : i_addr) & LINE_MASK;
                    beat_q    <= 3'd0;
                    rcnt      <= 4'd0;
                end
                ADDR: if (bus_reqack) begin
                    beat_q <= 3'd0;
                    rcnt   <= 4'd0;
                end
                WDATA: if (bus_reqack) beat_q <= beat_q + 3'd1;
                RESP: begin
                    // Foreign-tag beats are acknowledged but never forwarded.
                    respack_q <= bus_respcyc;
                    rvalid_q  <= resp_match;
                    if (resp_match) begin
                        rdata_q <= bus_resp;
                        beat_q  <= rcnt[2:0];
                        rcnt    <= rcnt + 4'd1;
                    end
                end
                DONE: last_grant_d <= owner_d;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        d_wnext    = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(line_addr);
                bus_reqtag = issued_tag;
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = d_wdata;
                bus_reqtag = TAG_WRITE;
                d_wnext    = bus_reqack;
            end
            DONE: begin
                i_done = ~owner_d;
                d_done = owner_d;
            end
            default: ;
        endcase
    end

    assign i_rvalid    = rvalid_q & ~owner_d;
    assign d_rvalid    = rvalid_q & owner_d;
    assign i_rdata     = i_rvalid ? rdata_q : '0;
    assign d_rdata     = d_rvalid ? rdata_q : '0;
    assign bus_respack = respack_q;
    assign beat        = beat_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
`ifndef MEM_READ
`define MEM_READ 13'h1100
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h0100
`endif

module tb_mem_bus_arbiter;
    localparam int TW = 13;
    localparam logic [TW-1:0] T_RD = TW'(`MEM_READ);
    localparam logic [TW-1:0] T_WR = TW'(`MEM_WRITE);
    localparam int K_REQ = 0, K_IRV = 1, K_DRV = 2, K_IDONE = 3, K_DDONE = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_req, i_rvalid, i_done, d_req, d_we, d_wnext, d_rvalid, d_done;
    logic [63:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, bus_req, bus_resp;
    logic [2:0] beat;
    logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [TW-1:0] bus_reqtag, bus_resptag;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done), .beat(beat),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    typedef struct {
        int          kind;
        logic [63:0] data;
        logic [TW-1:0] tag;
        int          aux;
    } ev_t;

    ev_t sb[$];
    int n_pass = 0, n_total = 0;
    int i_rv_seen = 0, respack_seen = 0;
    int cfg_stall = 0, cfg_gap = 0;
    bit cfg_foreign = 0, cfg_early = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic take(input int kind, input logic [63:0] data, input logic [TW-1:0] tag, input logic [2:0] b);
        ev_t e;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d data=%h beat=%0d, expected nothing", kind, data, b);
            return;
        end
        e = sb.pop_front();
        if (e.kind == kind && e.data === data && (kind != K_REQ || e.tag === tag) && (e.aux < 0 || e.aux == int'(b)))
            n_pass++;
        else
            $display("FAIL event: got kind=%0d data=%h tag=%h beat=%0d, expected kind=%0d data=%h tag=%h beat=%0d",
                     kind, data, tag, b, e.kind, e.data, e.tag, e.aux);
    endtask

    task automatic exp_read(input bit own_d, input logic [63:0] addr, input int nbeats, input bit with_done);
        logic [63:0] line;
        line = addr & ~64'h3f;
        sb.push_back('{kind: K_REQ, data: line, tag: T_RD, aux: -1});
        for (int k = 0; k < nbeats; k++)
            sb.push_back('{kind: own_d ? K_DRV : K_IRV, data: (line << 8) | (64'hA0 + 64'(k)), tag: '0, aux: k});
        if (with_done) sb.push_back('{kind: own_d ? K_DDONE : K_IDONE, data: 64'h0, tag: '0, aux: -1});
    endtask

    task automatic exp_write(input logic [63:0] addr, input logic [63:0] wbase);
        sb.push_back('{kind: K_REQ, data: addr & ~64'h3f, tag: T_WR, aux: -1});
        for (int k = 0; k < 8; k++)
            sb.push_back('{kind: K_REQ, data: wbase + 64'(k), tag: T_WR, aux: k});
        sb.push_back('{kind: K_DDONE, data: 64'h0, tag: '0, aux: -1});
    endtask

    task automatic outputs_zero(input string name);
        chk({name, "_ctrl"}, 64'({bus_reqcyc, bus_respack, i_rvalid, i_done, d_wnext, d_rvalid, d_done, beat}), 64'h0);
        chk({name, "_data"}, bus_req | i_rdata | d_rdata | 64'(bus_reqtag), 64'h0);
    endtask

    // Monitor: every DUT-presented event pops the scoreboard.
    initial begin
        bit prev_wait;
        logic [63:0] prev_req;
        logic [TW-1:0] prev_tag;
        prev_wait = 0;
        forever begin
            @(negedge clk);
            if (prev_wait && bus_reqcyc) begin
                chk("hold_bus_req", bus_req, prev_req);
                chk("hold_bus_reqtag", 64'(bus_reqtag), 64'(prev_tag));
            end
            if (bus_reqcyc && bus_reqack) take(K_REQ, bus_req, bus_reqtag, beat);
            if (i_rvalid) begin take(K_IRV, i_rdata, '0, beat); i_rv_seen++; end
            if (d_rvalid) take(K_DRV, d_rdata, '0, beat);
            if (i_done) take(K_IDONE, 64'h0, '0, 3'd0);
            if (d_done) take(K_DDONE, 64'h0, '0, 3'd0);
            if (d_wnext) chk("wnext_needs_ack", 64'(bus_reqcyc & bus_reqack), 64'h1);
            if (i_rvalid || d_rvalid) chk("single_rvalid", 64'(i_rvalid & d_rvalid), 64'h0);
            if (!i_rvalid && !d_rvalid && (i_rdata | d_rdata) != 64'h0) chk("non_owner_rdata", i_rdata | d_rdata, 64'h0);
            if (bus_respack) respack_seen++;
            prev_wait = reset && bus_reqcyc && !bus_reqack;
            prev_req  = bus_req;
            prev_tag  = bus_reqtag;
        end
    end

    // Memory model: acks after cfg_stall cycles, returns 8 read beats with cfg_gap idle cycles.
    initial begin
        int stall_cnt, wr_left, gap, beat_i;
        bit rd_busy, foreign_pend;
        logic [63:0] maddr;
        bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
        stall_cnt = 0; wr_left = 0; gap = 0; beat_i = 0; rd_busy = 0; foreign_pend = 0; maddr = '0;
        forever begin
            @(posedge clk); #1;
            bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
            if (!reset) begin
                stall_cnt = 0; wr_left = 0; rd_busy = 0;
            end else begin
                if (rd_busy) begin
                    if (gap > 0) gap--;
                    else if (foreign_pend && beat_i == 3) begin
                        bus_respcyc = 1; bus_resptag = T_WR; bus_resp = 64'hDEAD; foreign_pend = 0; gap = cfg_gap;
                    end else begin
                        bus_respcyc = 1; bus_resptag = T_RD; bus_resp = (maddr << 8) | (64'hA0 + 64'(beat_i));
                        beat_i++; gap = cfg_gap;
                        if (beat_i == 8) rd_busy = 0;
                    end
                end
                if (bus_reqcyc) begin
                    if (stall_cnt < cfg_stall) stall_cnt++;
                    else begin
                        bus_reqack = 1; stall_cnt = 0;
                        if (wr_left > 0) wr_left--;
                        else if (bus_reqtag == T_WR) wr_left = 8;
                        else begin
                            rd_busy = 1; maddr = bus_req; beat_i = 0; gap = cfg_gap; foreign_pend = cfg_foreign;
                            if (cfg_early) begin bus_respcyc = 1; bus_resptag = T_RD; bus_resp = 64'hBAD; end
                        end
                    end
                end
            end
        end
    end

    task automatic run_i(input logic [63:0] addr, input bit drop);
        bit dn;
        dn = 0;
        i_req = 1; i_addr = addr;
        for (int n = 0; n < 600 && !dn; n++) begin
            @(negedge clk); dn = i_done;
            @(posedge clk); #1;
        end
        if (!dn) begin n_total++; $display("FAIL i_done_timeout: got no i_done, required one within 600 cycles"); end
        if (drop || !dn) i_req = 0;
    endtask

    task automatic run_d(input bit we, input logic [63:0] addr, input logic [63:0] wbase, input bit drop);
        bit dn, wn;
        dn = 0;
        d_req = 1; d_we = we; d_addr = addr; d_wdata = wbase;
        for (int n = 0; n < 600 && !dn; n++) begin
            @(negedge clk); dn = d_done; wn = d_wnext;
            @(posedge clk); #1;
            if (wn) d_wdata = d_wdata + 64'h1;
        end
        if (!dn) begin n_total++; $display("FAIL d_done_timeout: got no d_done, required one within 600 cycles"); end
        if (drop || !dn) begin d_req = 0; d_we = 0; end
    endtask

    task automatic drained(input string name);
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk); #2;
        chk(name, 64'(sb.size()), 64'h0);
        sb.delete();
    endtask

    initial begin
        int rv0, ra0;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        #1 reset = 0;
        #1 outputs_zero("reset_state");
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;

        // Conflict from reset: I first (last_grant=D), then strict alternation.
        for (int r = 0; r < 4; r++) begin
            exp_read(0, 64'h4000 + 64'(r * 64 + r), 8, 1);
            exp_read(1, 64'h8005 + 64'(r * 64), 8, 1);
        end
        fork
            begin for (int r = 0; r < 4; r++) run_i(64'h4000 + 64'(r * 64 + r), r == 3); end
            begin for (int r = 0; r < 4; r++) run_d(0, 64'h8005 + 64'(r * 64), 64'h0, r == 3); end
        join
        drained("conflict_drained");

        exp_read(0, 64'h1047, 8, 1);
        run_i(64'h1047, 1);
        drained("i_read_drained");

        exp_write(64'h2000, 64'h10);
        run_d(1, 64'h2000, 64'h10, 1);
        drained("d_write_drained");

        cfg_stall = 5;
        exp_write(64'h2A47, 64'h30);
        run_d(1, 64'h2A47, 64'h30, 1);
        exp_read(1, 64'h5000, 8, 1);
        run_d(0, 64'h5000, 64'h0, 1);
        drained("stall_drained");
        cfg_stall = 0;

        cfg_gap = 2; cfg_foreign = 1; cfg_early = 1;
        ra0 = respack_seen;
        exp_read(0, 64'h6010, 8, 1);
        run_i(64'h6010, 1);
        drained("gap_foreign_drained");
        chk("respack_count", 64'(respack_seen - ra0), 64'd9);
        cfg_gap = 0; cfg_foreign = 0; cfg_early = 0;

        // Abort by reset after the third forwarded beat.
        exp_read(0, 64'h7008, 3, 0);
        rv0 = i_rv_seen;
        i_req = 1; i_addr = 64'h7008;
        for (int n = 0; n < 200 && i_rv_seen - rv0 < 3; n++) begin @(negedge clk); #2; end
        reset = 0;
        #1 outputs_zero("abort_reset");
        i_req = 0;
        repeat (3) @(negedge clk);
        #2 chk("abort_beats", 64'(i_rv_seen - rv0), 64'd3);
        @(posedge clk); #1 reset = 1;
        drained("abort_drained");
        @(posedge clk); #1;
        exp_read(0, 64'h7040, 8, 1);
        run_i(64'h7040, 1);
        drained("after_abort_drained");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
